chip8_mem_arbiter: RTL
======================

CHIP8_MEM_ARBITER -- requirements
Module: chip8_mem_arbiter

Interface
REQ-001 The block SHALL have parameter READ_LATENCY, default 2: downstream BRAM read latency in cycles, legal range 1..4.
REQ-002 The block SHALL have port clk_in, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req_valid_in, input, 3 bits: per-port request strobe; port 0 = CPU, port 1 = video draw/clear unit, port 2 = display scanout.
REQ-005 The block SHALL have port req_we_in, input, 3 bits: per-port write enable; 1 = write, 0 = read.
REQ-006 The block SHALL have port req_type_in, input, 3 bits: per-port target; 0 = RAM, 1 = VRAM.
REQ-007 The block SHALL have port req_addr_in, input, 48 bits: per-port 16-bit address; port i occupies bits [16i+15:16i].
REQ-008 The block SHALL have port req_data_in, input, 24 bits: per-port 8-bit write data; port i occupies bits [8i+7:8i].
REQ-009 The block SHALL have port ready_out, input-side handshake output, 3 bits: per-port slot grant; at most one bit is high in any cycle.
REQ-010 The block SHALL have port rvalid_out, output, 3 bits: per-port one-cycle read-response strobe.
REQ-011 The block SHALL have port rdata_out, output, 8 bits: read data, valid only while any rvalid_out bit is high.
REQ-012 The block SHALL have ports ram_en_out (1 bit), ram_we_out (1 bit), ram_addr_out (12 bits) and ram_data_out (8 bits), all outputs, and ram_data_in (8 bits), input: the 4096-byte RAM BRAM port.
REQ-013 The block SHALL have ports vram_en_out (1 bit), vram_we_out (1 bit), vram_addr_out (8 bits) and vram_data_out (8 bits), all outputs, and vram_data_in (8 bits), input: the 256-byte VRAM BRAM port.

Function
REQ-014 The block SHALL implement a slot scheduler FSM with states GRANT and SAMPLE, alternating every cycle, plus a 2-bit round-robin pointer p with sequence 0 -> 1 -> 2 -> 0.
REQ-015 In GRANT, the block SHALL drive ready_out = (1 << p) for exactly that one cycle.
REQ-016 In SAMPLE, the block SHALL drive ready_out = 0, sample port p's req_* signals, and advance p.
REQ-017 Each port SHALL get one slot every 6 cycles, whether or not it uses the slot.
REQ-018 The block SHALL ignore req_valid_in bits outside SAMPLE and bits for ports other than p; ignored requests produce no memory activity and no response.
REQ-019 For a request accepted in SAMPLE at cycle T, the block SHALL drive the selected BRAM port at T+1: en=1, we=req_we, data=req_data.
REQ-020 The RAM address SHALL be addr[11:0] and the VRAM address SHALL be addr[7:0]; upper address bits are ignored, so addresses wrap.
REQ-021 The non-selected BRAM port SHALL have en=0 at T+1, and both en outputs SHALL be 0 in every cycle with no accepted request.
REQ-022 For an accepted read, the block SHALL assert rvalid_out[port] for exactly one cycle at T+2+READ_LATENCY, with rdata_out registered from ram_data_in or vram_data_in according to the captured type.
REQ-023 Read-response tracking SHALL use a shift pipeline (valid, port, type) of depth READ_LATENCY+1.
REQ-024 Because slots are 2 cycles apart, responses SHALL never collide, and in-order return SHALL be guaranteed.
REQ-025 Accepted writes SHALL produce no rvalid_out.
REQ-026 A write followed by a read of the same address SHALL return the written value, since BRAM port order equals acceptance order.
REQ-027 Simultaneous req_valid_in on several ports SHALL be legal; only port p is served in that slot.
REQ-028 A requester that deasserts req_valid_in before its SAMPLE cycle SHALL lose its request silently.
REQ-029 rdata_out SHALL hold its last value when no rvalid_out bit is high.

Reset
REQ-030 While rst_in is high, the block SHALL force the FSM to GRANT, p=0, ready_out=0, rvalid_out=0, rdata_out=0, ram_en_out=0, vram_en_out=0, and both we outputs to 0, and SHALL clear the response pipeline.
REQ-031 The first cycle after rst_in falls SHALL be GRANT with ready_out=3'b001.
REQ-032 Reads in flight when rst_in asserts SHALL be discarded: no rvalid_out is produced for them after reset.

Verification
REQ-033 Bench SHALL cover idle rotation: no requests -> ready_out cycles 001,000,010,000,100,000 repeating; en outputs stay 0.
REQ-034 Bench SHALL cover RAM read: port 1 reads type 0, addr 0x0234, with ram_data_in=0xA5 at the expected cycle -> ram_en_out/ram_addr_out=0x234 at T+1; rvalid_out=3'b010 and rdata_out=0xA5 at T+4 (READ_LATENCY=2).
REQ-035 Bench SHALL cover VRAM write then read: port 1 writes 0x3C to VRAM addr 0x0107, then reads it in its next slot -> vram_we_out=1, vram_addr_out=0x07; read returns 0x3C on rvalid_out[1].
REQ-036 Bench SHALL cover contention: all three ports hold valid reads continuously -> service order 0,1,2,0,...; responses arrive 2 cycles apart and are never simultaneous.
REQ-037 Bench SHALL cover off-slot and wrong-port valid: port 2 pulses valid while ready_out=001 -> no memory access and no response.
REQ-038 Bench SHALL cover reset mid-read: rst_in asserted at T+2 of a port-0 read -> no rvalid_out ever appears; first post-reset ready_out=001.

Source files
------------

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter
// Time-slot arbiter that shares one RAM BRAM port (4096 bytes) and one VRAM
// BRAM port (256 bytes) between three requesters:
//   port 0 = CPU, port 1 = video draw/clear unit, port 2 = display scanout.
// A two-state scheduler alternates GRANT and SAMPLE every cycle while a
// round-robin pointer walks 0 -> 1 -> 2. Each port therefore owns one slot
// every 6 cycles, whether or not it uses it.
//
// Ports:
//   clk_in, rst_in            : clock, synchronous active-high reset
//   req_valid_in/we/type[2:0] : per-port request strobe, write enable, target
//                               (type 0 = RAM, 1 = VRAM)
//   req_addr_in[47:0]         : per-port 16-bit address, port i at [16i+15:16i]
//   req_data_in[23:0]         : per-port 8-bit write data, port i at [8i+7:8i]
//   ready_out[2:0]            : one-hot slot grant, high during GRANT only
//   rvalid_out[2:0]           : one-cycle read-response strobe per port
//   rdata_out[7:0]            : read data, held between responses
//   ram_*  / vram_*           : BRAM port signals (en, we, addr, data out/in)
module chip8_mem_arbiter #(
    parameter int READ_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [2:0]  req_valid_in,
    input  logic [2:0]  req_we_in,
    input  logic [2:0]  req_type_in,
    input  logic [47:0] req_addr_in,
    input  logic [23:0] req_data_in,
    output logic [2:0]  ready_out,
    output logic [2:0]  rvalid_out,
    output logic [7:0]  rdata_out,
    output logic        ram_en_out,
    output logic        ram_we_out,
    output logic [11:0] ram_addr_out,
    output logic [7:0]  ram_data_out,
    input  logic [7:0]  ram_data_in,
    output logic        vram_en_out,
    output logic        vram_we_out,
    output logic [7:0]  vram_addr_out,
    output logic [7:0]  vram_data_out,
    input  logic [7:0]  vram_data_in
);

    typedef enum logic {
        GRANT  = 1'b0,
        SAMPLE = 1'b1
    } slot_state_t;

    // One in-flight read: which port asked and which memory answers.
    typedef struct packed {
        logic       valid;
        logic [1:0] port;
        logic       vram;
    } rsp_t;

    slot_state_t             state;
    logic [1:0]              ptr;
    rsp_t [READ_LATENCY:0]   rsp_pipe;

    logic       accept;
    logic       sel_we;
    logic       sel_type;
    logic [7:0] sel_data;

    // Grant is a decode of the registered slot state. It is gated by reset so
    // the grant stays low while reset is held and appears in the very first
    // GRANT cycle once reset drops.
    assign ready_out = (state == GRANT && !rst_in) ? (3'b001 << ptr) : 3'b000;

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        accept   = 1'b0;
        sel_we   = req_we_in[ptr];
        sel_type = req_type_in[ptr];
        sel_data = req_data_in[{ptr, 3'b000} +: 8];
        if (state == SAMPLE) begin
            accept = req_valid_in[ptr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= GRANT;
            ptr         <= 2'd0;
            rvalid_out  <= 3'b000;
            rdata_out   <= 8'h00;
            ram_en_out  <= 1'b0;
            ram_we_out  <= 1'b0;
            vram_en_out <= 1'b0;
            vram_we_out <= 1'b0;
            rsp_pipe    <= '0;
        end else begin
            // Enables are one-cycle pulses: low unless a request was just accepted.
            ram_en_out  <= 1'b0;
            ram_we_out  <= 1'b0;
            vram_en_out <= 1'b0;
            vram_we_out <= 1'b0;

            case (state)
                GRANT: begin
                    state <= SAMPLE;
                end
                SAMPLE: begin
                    state <= GRANT;
                    ptr   <= (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
                    if (accept) begin
                        if (sel_type) begin
                            vram_en_out <= 1'b1;
                            vram_we_out <= sel_we;
                        end else begin
                            ram_en_out <= 1'b1;
                            ram_we_out <= sel_we;
                        end
                    end
                end
                default: state <= GRANT;
            endcase

            // Stage 0 is loaded together with the BRAM enable; stage
            // READ_LATENCY lines up with the cycle the BRAM output is valid.
            rsp_pipe[0].valid <= accept && !sel_we;
            rsp_pipe[0].port  <= ptr;
            rsp_pipe[0].vram  <= sel_type;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                rsp_pipe[i] <= rsp_pipe[i-1];
            end

            if (rsp_pipe[READ_LATENCY].valid) begin
                rvalid_out <= 3'b001 << rsp_pipe[READ_LATENCY].port;
                rdata_out  <= rsp_pipe[READ_LATENCY].vram ? vram_data_in : ram_data_in;
            end else begin
                rvalid_out <= 3'b000;
            end
        end
    end

    // NOTE: address and write-data registers carry no reset; they are only
    // looked at while an enable is high, and enables are reset above.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            ram_addr_out  <= req_addr_in[{ptr, 4'b0000} +: 12];
            vram_addr_out <= req_addr_in[{ptr, 4'b0000} +: 8];
            ram_data_out  <= sel_data;
            vram_data_out <= sel_data;
        end
    end

endmodule
